// File: rtl/tdm_demux8.sv
// tdm_demux8 -- receive end of the 8:1 time-division link.
//
// Collects one DW-bit slot per valid beat into a shadow register and, once
// the last slot (or the trailing parity beat) arrives, copies the frame to a
// registered output with a single-cycle valid pulse. A frame_start seen in
// the middle of a frame drops the partial frame, flags sync_err and restarts
// collection from that beat.
//
// Build option: define TDM_DEMUX_PARITY_EN to expect one extra even-parity
// beat after the data slots (parity bit = XOR of all data bits, carried on
// din[0]). Without it, parity_err is held at 0. The port list is the same in
// both builds.
//
// Ports
//   clk          in   1         clock, all logic on posedge
//   rst          in   1         synchronous reset, active-high
//   din          in   DW        slot data
//   din_valid    in   1         din / frame_start valid this cycle
//   frame_start  in   1         this valid beat is slot 0
//   dout         out  SLOTS*DW  last completed frame, slot k at dout[k*DW +: DW]
//   dout_valid   out  1         1-cycle pulse, dout just updated
//   busy         out  1         a frame is partially collected
//   sync_err     out  1         1-cycle pulse, frame_start arrived mid-frame
//   parity_err   out  1         1-cycle pulse with dout_valid on parity mismatch
module tdm_demux8 #(
  parameter int DW    = 1,
  parameter int SLOTS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DW-1:0]       din,
  input  logic                din_valid,
  input  logic                frame_start,
  output logic [SLOTS*DW-1:0] dout,
  output logic                dout_valid,
  output logic                busy,
  output logic                sync_err,
  output logic                parity_err
);

  localparam int CW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam logic [CW-1:0] LAST = CW'(SLOTS - 1);

`ifdef TDM_DEMUX_PARITY_EN
  typedef enum logic [1:0] {IDLE, COLLECT, PARITY} state_t;
`else
  typedef enum logic {IDLE, COLLECT} state_t;
`endif

  state_t                state, state_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic [SLOTS*DW-1:0]   shadow, shadow_n;
  logic [SLOTS*DW-1:0]   dout_n;
  logic                  dout_valid_n;
  logic                  sync_err_n;
  logic                  parity_err_n;

  // Next-state / next-output decode
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    shadow_n     = shadow;
    dout_n       = dout;
    dout_valid_n = 1'b0;
    sync_err_n   = 1'b0;
    parity_err_n = 1'b0;

    if (din_valid) begin
      unique case (state)
        IDLE: begin
          // Beats without frame_start are discarded until the link re-syncs.
          if (frame_start) begin
            shadow_n[DW-1:0] = din;
            cnt_n            = CW'(1);
            state_n          = COLLECT;
          end
        end

        COLLECT: begin
          if (frame_start) begin
            // Mid-frame restart: drop the partial frame, this beat is slot 0.
            sync_err_n       = 1'b1;
            shadow_n[DW-1:0] = din;
            cnt_n            = CW'(1);
          end else begin
            shadow_n[int'(cnt)*DW +: DW] = din;
            if (cnt == LAST) begin
              cnt_n = '0;
`ifdef TDM_DEMUX_PARITY_EN
              state_n = PARITY;
`else
              dout_n       = shadow_n;
              dout_valid_n = 1'b1;
              state_n      = IDLE;
`endif
            end else begin
              cnt_n = cnt + CW'(1);
            end
          end
        end

`ifdef TDM_DEMUX_PARITY_EN
        PARITY: begin
          if (frame_start) begin
            sync_err_n       = 1'b1;
            shadow_n[DW-1:0] = din;
            cnt_n            = CW'(1);
            state_n          = COLLECT;
          end else begin
            // Even parity: din[0] must equal the XOR of all data bits.
            dout_n       = shadow;
            dout_valid_n = 1'b1;
            parity_err_n = (din[0] != ^shadow);
            state_n      = IDLE;
          end
        end
`endif

        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  // Registered state and outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      shadow     <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      sync_err   <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      shadow     <= shadow_n;
      dout       <= dout_n;
      dout_valid <= dout_valid_n;
      sync_err   <= sync_err_n;
      parity_err <= parity_err_n;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_tdm_demux8.sv
// Testbench for tdm_demux8 (DW=1, SLOTS=8). Expected frames are queued when
// the last beat of a frame is driven and popped by a monitor when dout_valid
// is seen. Honors TDM_DEMUX_PARITY_EN the same way the design does.
module tb_tdm_demux8;

  localparam int DW    = 1;
  localparam int SLOTS = 8;
`ifdef TDM_DEMUX_PARITY_EN
  localparam int FR = SLOTS + 1;
`else
  localparam int FR = SLOTS;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic [DW-1:0]       din;
  logic                din_valid;
  logic                frame_start;
  logic [SLOTS*DW-1:0] dout;
  logic                dout_valid;
  logic                busy;
  logic                sync_err;
  logic                parity_err;

  tdm_demux8 #(.DW(DW), .SLOTS(SLOTS)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .frame_start(frame_start),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy),
    .sync_err   (sync_err),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_q[$];
  logic       exp_p[$];

  int cyc     = 0;
  int v_cyc   = 0;
  int v_prev  = 0;
  int n_valid = 0;
  int n_sync  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge
  initial begin
    logic [7:0] e;
    logic       pe;
    forever begin
      @(negedge clk);
      cyc++;
      if (sync_err) n_sync++;
      if (dout_valid) begin
        n_valid++;
        v_prev = v_cyc;
        v_cyc  = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 32'd1, 32'd0);
        end else begin
          e  = exp_q.pop_front();
          pe = exp_p.pop_front();
          check("dout", 32'(dout), 32'(e));
          check("parity_err", 32'(parity_err), 32'(pe));
        end
      end
    end
  end

  task automatic beat(input logic d, input logic fs);
    din         = d;
    din_valid   = 1'b1;
    frame_start = fs;
    @(posedge clk);
    #1;
    din_valid   = 1'b0;
    frame_start = 1'b0;
    din         = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Sends one full frame; gap_len idle cycles are inserted after slot gap_at.
  // pbit is the parity beat sent when the parity build is selected.
  task automatic send_frame(input logic [7:0] v, input int gap_at, input int gap_len,
                            input logic pbit);
    for (int k = 0; k < SLOTS; k++) begin
`ifndef TDM_DEMUX_PARITY_EN
      if (k == SLOTS - 1) begin
        exp_q.push_back(v);
        exp_p.push_back(1'b0);
      end
`endif
      beat(v[k], k == 0);
      if (k == gap_at) idle(gap_len);
    end
`ifdef TDM_DEMUX_PARITY_EN
    exp_q.push_back(v);
    exp_p.push_back(pbit != ^v);
    beat(pbit, 1'b0);
`else
    if (pbit) idle(0);
`endif
  endtask

  initial begin
    int c0, l1, l2, s0, nv0;
    rst = 1'b1; din = '0; din_valid = 1'b0; frame_start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_dout_valid", 32'(dout_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sync_err", 32'(sync_err), 32'd0);
    check("rst_parity_err", 32'(parity_err), 32'd0);
    rst = 1'b0;
    idle(1);

    // Test 1: continuous frame 0x96
    c0 = cyc;
    send_frame(8'h96, -1, 0, 1'b0);
    check("t1_busy_after", 32'(busy), 32'd0);
    idle(1);
    check("t1_valid_pulse", 32'(dout_valid), 32'd0);
    check("t1_dout_hold", 32'(dout), 32'h96);
    idle(2);
    l1 = v_cyc - c0;

    // Test 2: 0xE8 with two stalled cycles after slot 3
    c0 = cyc;
    send_frame(8'hE8, 3, 2, 1'b0);
    idle(3);
    l2 = v_cyc - c0;
    check("t2_latency", 32'(l2), 32'(l1 + 2));

    // Test 3: restart at slot 5, then a clean frame of ones
    s0  = n_sync;
    nv0 = n_valid;
    beat(1'b0, 1'b1);
    for (int k = 1; k < 5; k++) beat(1'b1, 1'b0);
    send_frame(8'hFF, -1, 0, 1'b0);
    idle(2);
    check("t3_sync_pulses", 32'(n_sync - s0), 32'd1);
    check("t3_valid_count", 32'(n_valid - nv0), 32'd1);

    // Test 4: reset after slot 4 discards the partial frame
    beat(1'b1, 1'b1);
    for (int k = 1; k < 5; k++) beat(1'b0, 1'b0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("t4_dout", 32'(dout), 32'd0);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_dout_valid", 32'(dout_valid), 32'd0);
    nv0 = n_valid;
    for (int k = 0; k < 10; k++) beat(1'b1, 1'b0);
    idle(1);
    check("t4_ignored_busy", 32'(busy), 32'd0);
    check("t4_ignored_dout", 32'(dout), 32'd0);
    check("t4_ignored_valid", 32'(n_valid - nv0), 32'd0);
    send_frame(8'h5A, -1, 0, 1'b0);
    idle(2);

`ifdef TDM_DEMUX_PARITY_EN
    // Test 5: parity good then bad
    send_frame(8'h96, -1, 0, 1'b0);
    idle(2);
    send_frame(8'h96, -1, 0, 1'b1);
    idle(2);
`endif

    // Test 6: back-to-back frames
    nv0 = n_valid;
    send_frame(8'h96, -1, 0, 1'b0);
    send_frame(8'hE8, -1, 0, 1'b0);
    idle(3);
    check("t6_valid_count", 32'(n_valid - nv0), 32'd2);
    check("t6_spacing", 32'(v_cyc - v_prev), 32'(FR));

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
